sap1_controller_sequencer: RTL and testbench

- Control unit for the SAP-1 datapath. It sequences the program counter, MAR, RAM, instruction register, accumulator, B register, adder/subtractor and output register through a 6-state ring counter (T1..T6).
- It decodes the instruction-register opcode and drives a 12-bit control word into the active-low load enables of the 8-bit registers.
- A run input gates sequencing. HLT freezes the machine until reset.

---
 rtl/sap1_pkg.sv | 49 ++++
 rtl/sap1_controller_sequencer_ring_counter_6.sv | 45 ++++
 rtl/sap1_controller_sequencer.sv | 99 +++++++++
 tb/tb_sap1_controller_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 controller/sequencer.
//   - Opcode encodings (IR[7:4]).
//   - Control-word bit indices, MSB first:
//     {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}.
//   - Control-word constants for every ring state / instruction.
//   - One-hot ring state encoding (T1..T6).
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  // All strobes inactive: every active-low load enable high, every bus driver off.
  localparam logic [11:0] CW_IDLE      = 12'h3E3;
  localparam logic [11:0] CW_FETCH_T1  = 12'h5E3; // ep, lm_n: PC -> MAR
  localparam logic [11:0] CW_FETCH_T2  = 12'hBE3; // cp: PC increment
  localparam logic [11:0] CW_FETCH_T3  = 12'h263; // ce_n, li_n: RAM -> IR
  localparam logic [11:0] CW_ADDR_T4   = 12'h1A3; // ei_n, lm_n: IR operand -> MAR
  localparam logic [11:0] CW_LDA_T5    = 12'h2C3; // ce_n, la_n: RAM -> A
  localparam logic [11:0] CW_MEM_TO_B  = 12'h2E1; // ce_n, lb_n: RAM -> B
  localparam logic [11:0] CW_ADD_T6    = 12'h3C7; // eu, la_n: sum -> A
  localparam logic [11:0] CW_SUB_T6    = 12'h3CF; // su, eu, la_n: difference -> A
  localparam logic [11:0] CW_OUT_T4    = 12'h3F2; // ea, lo_n: A -> output register

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/sap1_controller_sequencer_ring_counter_6.sv
// ring_counter_6: one-hot six-state ring counter T1 -> ... -> T6 -> T1.
// Ports:
//   clk     in   system clock
//   clr     in   asynchronous active-low reset, returns the ring to T1
//   en      in   1 = advance one state on the rising edge, 0 = hold
//   t_state out  current one-hot state (bit0 = T1)
module ring_counter_6
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output t_state_e   t_state
);

  t_state_e state_reg;
  t_state_e state_next;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= T1;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (en) begin
      case (state_reg)
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3:      state_next = T4;
        T4:      state_next = T5;
        T5:      state_next = T6;
        T6:      state_next = T1;
        // Any non-one-hot value (e.g. after an upset) recovers to T1.
        default: state_next = T1;
      endcase
    end
  end

  assign t_state = state_reg;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 control unit.
// Sequences fetch (T1..T3) and execute (T4..T6) and decodes the opcode into
// the 12-bit control word driving the datapath.
// Ports:
//   clk     in   system clock
//   clr     in   asynchronous active-low reset
//   run     in   1 = sequence, 0 = hold state with an idle control word
//   opcode  in   IR[7:4], meaningful from T4 on
//   con     out  control word {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
//   t_state out  one-hot ring state, bit0 = T1
//   halted  out  set when HLT executes, cleared only by clr
module sap1_controller_sequencer
  import sap1_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        halted
);

  t_state_e    ring_state;
  logic        halted_reg;
  logic        halted_next;
  logic        hlt_take;
  logic        ring_en;
  logic [11:0] cw_decode;

  // HLT is only taken on an edge where the machine is actually running.
  // On that edge the ring must not advance, so the frozen state stays T4.
  assign hlt_take = run && !halted_reg && (ring_state == T4) && (opcode == OP_HLT);
  assign ring_en  = run && !halted_reg && !hlt_take;

  ring_counter_6 u_ring (
    .clk     (clk),
    .clr     (clr),
    .en      (ring_en),
    .t_state (ring_state)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    halted_next = halted_reg | hlt_take;
  end

  // Fetch words ignore opcode; execute words select on it.
  always_comb begin
    cw_decode = CW_IDLE;
    case (ring_state)
      T1: cw_decode = CW_FETCH_T1;
      T2: cw_decode = CW_FETCH_T2;
      T3: cw_decode = CW_FETCH_T3;
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: cw_decode = CW_ADDR_T4;
          OP_OUT:                 cw_decode = CW_OUT_T4;
          default:                cw_decode = CW_IDLE;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA:         cw_decode = CW_LDA_T5;
          OP_ADD, OP_SUB: cw_decode = CW_MEM_TO_B;
          default:        cw_decode = CW_IDLE;
        endcase
      end
      T6: begin
        case (opcode)
          OP_ADD:  cw_decode = CW_ADD_T6;
          OP_SUB:  cw_decode = CW_SUB_T6;
          default: cw_decode = CW_IDLE;
        endcase
      end
      default: cw_decode = CW_IDLE;
    endcase
  end

  // clr gates the word directly so no strobe is asserted while reset is held,
  // independent of how quickly the ring register clears.
  always_comb begin
    con = CW_IDLE;
    if (clr && run && !halted_reg) begin
      con = cw_decode;
    end
  end

  assign t_state = ring_state;
  assign halted  = halted_reg;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
module tb_sap1_controller_sequencer;

  logic        clk;
  logic        clr;
  logic        run;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halted;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    logic [5:0]  t;
    logic [11:0] cw;
    logic        h;
    string       tag;
  } exp_t;

  exp_t sb[$];

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  sap1_controller_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .opcode  (opcode),
    .con     (con),
    .t_state (t_state),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    assert_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive inputs between edges, record the expected outputs, then compare
  // once the combinational outputs have settled; finally move to the next
  // drive point (the following falling edge).
  task automatic step(input logic c, input logic r, input logic [3:0] op,
                      input logic [5:0] et, input logic [11:0] ecw, input logic eh,
                      input string tag);
    exp_t e;
    int   drivers;
    clr    = c;
    run    = r;
    opcode = op;
    e.t = et; e.cw = ecw; e.h = eh; e.tag = tag;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      assert_cnt++;
      fail_cnt++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_t"},   {6'd0, t_state}, {6'd0, e.t});
      chk({e.tag, "_con"}, con, e.cw);
      chk({e.tag, "_hlt"}, {11'd0, halted}, {11'd0, e.h});
      chk({e.tag, "_onehot"}, {11'd0, $onehot(t_state)}, 12'd1);
      drivers = int'(con[10]) + int'(!con[8]) + int'(!con[6]) + int'(con[4]) + int'(con[2]);
      chk({e.tag, "_wbus"}, {11'd0, drivers <= 1}, 12'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0;
    run = 1'b0;
    opcode = 4'h0;
    @(negedge clk);

    // Reset held with run=1: ring stays at T1 and the word stays idle.
    step(0, 1, 4'hF, S1, 12'h3E3, 0, "rst_hold");
    step(0, 1, 4'h1, S1, 12'h3E3, 0, "rst_hold2");

    // Fetch with HLT on the opcode lines must neither affect con nor halt.
    step(1, 1, 4'hF, S1, 12'h5E3, 0, "f_t1");
    step(1, 1, 4'hF, S2, 12'hBE3, 0, "f_t2");
    step(1, 1, 4'hE, S3, 12'h263, 0, "f_t3");
    // LDA
    step(1, 1, 4'h0, S4, 12'h1A3, 0, "lda_t4");
    step(1, 1, 4'h0, S5, 12'h2C3, 0, "lda_t5");
    step(1, 1, 4'h0, S6, 12'h3E3, 0, "lda_t6");
    // ADD
    step(1, 1, 4'h2, S1, 12'h5E3, 0, "add_t1");
    step(1, 1, 4'h2, S2, 12'hBE3, 0, "add_t2");
    step(1, 1, 4'h2, S3, 12'h263, 0, "add_t3");
    step(1, 1, 4'h1, S4, 12'h1A3, 0, "add_t4");
    step(1, 1, 4'h1, S5, 12'h2E1, 0, "add_t5");
    step(1, 1, 4'h1, S6, 12'h3C7, 0, "add_t6");
    // SUB
    step(1, 1, 4'h0, S1, 12'h5E3, 0, "sub_t1");
    step(1, 1, 4'h0, S2, 12'hBE3, 0, "sub_t2");
    step(1, 1, 4'h0, S3, 12'h263, 0, "sub_t3");
    step(1, 1, 4'h2, S4, 12'h1A3, 0, "sub_t4");
    step(1, 1, 4'h2, S5, 12'h2E1, 0, "sub_t5");
    step(1, 1, 4'h2, S6, 12'h3CF, 0, "sub_t6");
    // OUT
    step(1, 1, 4'h1, S1, 12'h5E3, 0, "out_t1");
    step(1, 1, 4'h1, S2, 12'hBE3, 0, "out_t2");
    step(1, 1, 4'h1, S3, 12'h263, 0, "out_t3");
    step(1, 1, 4'hE, S4, 12'h3F2, 0, "out_t4");
    step(1, 1, 4'hE, S5, 12'h3E3, 0, "out_t5");
    step(1, 1, 4'hE, S6, 12'h3E3, 0, "out_t6");

    // Pause during T2: PC increment strobe suppressed, state held.
    step(1, 1, 4'h0, S1, 12'h5E3, 0, "pz_t1");
    for (int i = 0; i < 5; i++) step(1, 0, 4'h0, S2, 12'h3E3, 0, "pz_hold");
    step(1, 1, 4'h0, S2, 12'hBE3, 0, "pz_resume");
    step(1, 1, 4'h0, S3, 12'h263, 0, "pz_t3");

    // Undefined opcode 0101: idle through execute, ring keeps cycling.
    step(1, 1, 4'h5, S4, 12'h3E3, 0, "nop_t4");
    step(1, 1, 4'h5, S5, 12'h3E3, 0, "nop_t5");
    step(1, 1, 4'h5, S6, 12'h3E3, 0, "nop_t6");
    step(1, 1, 4'h5, S1, 12'h5E3, 0, "nop_wrap");

    // Reset mid-T5 of ADD, asserted between edges.
    step(1, 1, 4'h1, S2, 12'hBE3, 0, "ar_t2");
    step(1, 1, 4'h1, S3, 12'h263, 0, "ar_t3");
    step(1, 1, 4'h1, S4, 12'h1A3, 0, "ar_t4");
    step(0, 1, 4'h1, S1, 12'h3E3, 0, "ar_clr");
    step(1, 1, 4'h0, S1, 12'h5E3, 0, "ar_rel");

    // HLT reached with run=0: not taken until run returns.
    step(1, 1, 4'h0, S2, 12'hBE3, 0, "h_t2");
    step(1, 1, 4'hF, S3, 12'h263, 0, "h_t3");
    step(1, 0, 4'hF, S4, 12'h3E3, 0, "h_norun");
    step(1, 0, 4'hF, S4, 12'h3E3, 0, "h_norun2");
    step(1, 1, 4'hF, S4, 12'h3E3, 0, "h_take");
    for (int i = 0; i < 20; i++) step(1, 1, 4'(i), S4, 12'h3E3, 1, "h_frozen");
    step(1, 0, 4'h0, S4, 12'h3E3, 1, "h_norun_frz");

    // Only clr leaves the halted state.
    step(0, 1, 4'h0, S1, 12'h3E3, 0, "h_clr");
    step(1, 1, 4'h0, S1, 12'h5E3, 0, "h_rel_t1");
    step(1, 1, 4'h0, S2, 12'hBE3, 0, "h_rel_t2");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
